reaction_timer_16: RTL and testbench

- Downstream consumer of the 16-bit programmable delay stage.
- Arms when the delay is triggered and lights the LED on the delay's time_out pulse.
- Counts elapsed milliseconds until the player's button rising edge, then holds the 16-bit binary result for the display stage.
- Flags presses made before the LED lights (early) and presses that never arrive (timeout).

---
 rtl/reaction_timer_16.sv | 149 ++++++++++++++
 tb/tb_reaction_timer_16.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_16.sv
// reaction_timer_16
//   Reaction-time measurement stage that sits behind the programmable delay.
//   An arm pulse starts a round, the delay's time_out pulse (start) lights the
//   LED, and the elapsed time in milliseconds is counted until the player's
//   button rising edge. The 16-bit binary result is held for the display until
//   the next arm. Presses before the LED lights are flagged as early; a round
//   where the count reaches MAX_MS without a press is flagged as timeout.
//
// Parameters
//   TICK_DIV     clk cycles per millisecond tick (>= 2)
//   MAX_MS       saturation limit and timeout threshold (<= 65535)
//
// Ports
//   clk          system clock, all state changes on posedge
//   reset_n      synchronous active-low reset
//   arm          single-cycle pulse that begins a round
//   start        single-cycle pulse from the delay stage's time_out
//   button       player button, active-high, synchronised and debounced
//   led          stimulus LED, high only while timing
//   busy         high while waiting for the LED or timing
//   result       reaction time in ms, held until the next arm
//   result_valid high after a legal press
//   early        high after a press made before the LED lit
//   timeout      high after the count reached MAX_MS without a press
module reaction_timer_16 #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned MAX_MS   = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic        start,
    input  logic        button,
    output logic        led,
    output logic        busy,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        early,
    output logic        timeout
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MS_MAX   = 16'(MAX_MS);
    // Count value on which the next tick reaches the limit.
    localparam logic [15:0]   MS_PRE   = 16'(MAX_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TIMING,
        S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [15:0]   ms_count;
    logic          btn_prev;
    logic          btn_rise;

    assign btn_rise = button & ~btn_prev;

    // NOTE: every register here, outputs included, is assigned with <= so all
    // of them update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            prescaler    <= '0;
            ms_count     <= '0;
            // Reset to 1 so a button already held down does not look like a press.
            btn_prev     <= 1'b1;
            led          <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            btn_prev <= button;

            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state        <= S_WAIT;
                        busy         <= 1'b1;
                        result       <= '0;
                        result_valid <= 1'b0;
                        early        <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end

                S_WAIT: begin
                    // A press before the LED lights takes priority over start.
                    if (btn_rise) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        early  <= 1'b1;
                        result <= '0;
                    end else if (start) begin
                        state     <= S_TIMING;
                        led       <= 1'b1;
                        prescaler <= '0;
                        ms_count  <= '0;
                    end
                end

                S_TIMING: begin
                    if (btn_rise) begin
                        // Capture the count before any coincident tick.
                        state        <= S_DONE;
                        led          <= 1'b0;
                        busy         <= 1'b0;
                        result       <= ms_count;
                        result_valid <= 1'b1;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler <= '0;
                        if (ms_count == MS_PRE) begin
                            state    <= S_DONE;
                            ms_count <= MS_MAX;
                            led      <= 1'b0;
                            busy     <= 1'b0;
                            result   <= MS_MAX;
                            timeout  <= 1'b1;
                        end else begin
                            ms_count <= ms_count + 16'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                S_DONE: begin
                    if (arm) begin
                        state        <= S_WAIT;
                        busy         <= 1'b1;
                        result       <= '0;
                        result_valid <= 1'b0;
                        early        <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_16.sv
// tb_reaction_timer_16
//   Directed bench for reaction_timer_16 with TICK_DIV=4 and MAX_MS=20.
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   that follows the rising edge under test. With start sampled at rising edge
//   s, ms_count equals k after edge s+4k, so a press sampled at edge s+n
//   reports floor((n-1)/4).
module tb_reaction_timer_16;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_MS   = 20;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        start;
    logic        button;
    logic        led;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        early;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    reaction_timer_16 #(
        .TICK_DIV(TICK_DIV),
        .MAX_MS  (MAX_MS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .arm         (arm),
        .start       (start),
        .button      (button),
        .led         (led),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .early       (early),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: each ends just after the rising edge that sampled it.
    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_reset();
        button = 1'b0;
        pulse_reset();
        n_cmp++; if (led !== 1'b0)          begin n_err++; $display("FAIL reset_led got %b want 0", led); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (result !== 16'd0)      begin n_err++; $display("FAIL reset_result got %0d want 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", result_valid); end
        n_cmp++; if (early !== 1'b0)        begin n_err++; $display("FAIL reset_early got %b want 0", early); end
        n_cmp++; if (timeout !== 1'b0)      begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
    endtask

    task automatic test_normal_press();
        pulse_arm();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy got %b want 1", busy); end
        n_cmp++; if (led !== 1'b0)  begin n_err++; $display("FAIL wait_led got %b want 0", led); end
        repeat (9) @(negedge clk);
        pulse_start();
        n_cmp++; if (led !== 1'b1)  begin n_err++; $display("FAIL start_led got %b want 1", led); end
        // Press sampled at edge s+13 -> 3 ms.
        repeat (12) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        n_cmp++; if (result !== 16'd3)      begin n_err++; $display("FAIL normal_result got %0d want 3", result); end
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL normal_valid got %b want 1", result_valid); end
        n_cmp++; if (led !== 1'b0)          begin n_err++; $display("FAIL normal_led got %b want 0", led); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL normal_busy got %b want 0", busy); end
        n_cmp++; if (early !== 1'b0 || timeout !== 1'b0)
            begin n_err++; $display("FAIL normal_flags got early=%b timeout=%b want 0 0", early, timeout); end
        button = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (result !== 16'd3)      begin n_err++; $display("FAIL normal_hold got %0d want 3", result); end
    endtask

    task automatic test_rearm();
        pulse_arm();
        n_cmp++; if (result !== 16'd0)      begin n_err++; $display("FAIL rearm_result got %0d want 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL rearm_valid got %b want 0", result_valid); end
        n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL rearm_busy got %b want 1", busy); end
    endtask

    task automatic test_early_press();
        // Entered in WAIT; this arm is ignored.
        pulse_arm();
        @(negedge clk) button = 1'b1;
        @(negedge clk);
        n_cmp++; if (early !== 1'b1)        begin n_err++; $display("FAIL early_flag got %b want 1", early); end
        n_cmp++; if (result !== 16'd0)      begin n_err++; $display("FAIL early_result got %0d want 0", result); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL early_valid got %b want 0", result_valid); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL early_busy got %b want 0", busy); end
        button = 1'b0;
        pulse_start();
        @(negedge clk);
        n_cmp++; if (led !== 1'b0 || busy !== 1'b0 || early !== 1'b1)
            begin n_err++; $display("FAIL early_then_start got led=%b busy=%b early=%b want 0 0 1", led, busy, early); end
    endtask

    task automatic test_simultaneous_start();
        pulse_arm();
        @(negedge clk) begin button = 1'b1; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        n_cmp++; if (early !== 1'b1 || led !== 1'b0)
            begin n_err++; $display("FAIL simul_early got early=%b led=%b want 1 0", early, led); end
        button = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_arm();
        pulse_start();
        repeat (79) @(negedge clk);
        n_cmp++; if (led !== 1'b1 || timeout !== 1'b0)
            begin n_err++; $display("FAIL pre_timeout got led=%b timeout=%b want 1 0", led, timeout); end
        @(negedge clk);
        n_cmp++; if (timeout !== 1'b1)      begin n_err++; $display("FAIL timeout_flag got %b want 1", timeout); end
        n_cmp++; if (result !== 16'd20)     begin n_err++; $display("FAIL timeout_result got %0d want 20", result); end
        n_cmp++; if (led !== 1'b0)          begin n_err++; $display("FAIL timeout_led got %b want 0", led); end
        n_cmp++; if (result_valid !== 1'b0 || early !== 1'b0)
            begin n_err++; $display("FAIL timeout_others got valid=%b early=%b want 0 0", result_valid, early); end
        repeat (10) @(negedge clk);
        n_cmp++; if (result !== 16'd20)     begin n_err++; $display("FAIL timeout_hold got %0d want 20", result); end
    endtask

    task automatic test_tick_coincide();
        pulse_arm();
        pulse_start();
        // Edge s+24 is the wrap that would move 5 -> 6.
        repeat (23) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        n_cmp++; if (result !== 16'd5 || result_valid !== 1'b1)
            begin n_err++; $display("FAIL tick_coincide got result=%0d valid=%b want 5 1", result, result_valid); end
        button = 1'b0;
    endtask

    task automatic test_press_at_max();
        pulse_arm();
        pulse_start();
        // Edge s+80 is the tick that would reach MAX_MS.
        repeat (79) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        n_cmp++; if (result !== 16'd19)     begin n_err++; $display("FAIL max_press_result got %0d want 19", result); end
        n_cmp++; if (result_valid !== 1'b1 || timeout !== 1'b0)
            begin n_err++; $display("FAIL max_press_flags got valid=%b timeout=%b want 1 0", result_valid, timeout); end
        button = 1'b0;
    endtask

    task automatic test_held_button();
        button = 1'b1;
        pulse_reset();
        pulse_arm();
        pulse_start();
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || led !== 1'b1 || result_valid !== 1'b0 || early !== 1'b0)
            begin n_err++; $display("FAIL held_no_capture got busy=%b led=%b valid=%b early=%b want 1 1 0 0",
                                    busy, led, result_valid, early); end
        button = 1'b0;
        repeat (3) @(negedge clk);
        // Press sampled at edge s+9 -> 2 ms.
        button = 1'b1;
        @(negedge clk);
        n_cmp++; if (result !== 16'd2 || result_valid !== 1'b1)
            begin n_err++; $display("FAIL held_recapture got result=%0d valid=%b want 2 1", result, result_valid); end
        button = 1'b0;
    endtask

    task automatic test_reset_mid_timing();
        pulse_arm();
        pulse_start();
        repeat (28) @(negedge clk);
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL mid_pre_led got %b want 1", led); end
        pulse_reset();
        n_cmp++; if (led !== 1'b0 || busy !== 1'b0 || result !== 16'd0 ||
                     result_valid !== 1'b0 || early !== 1'b0 || timeout !== 1'b0)
            begin n_err++; $display("FAIL mid_reset got led=%b busy=%b result=%0d valid=%b early=%b timeout=%b want all 0",
                                    led, busy, result, result_valid, early, timeout); end
        pulse_start();
        @(negedge clk);
        n_cmp++; if (led !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL mid_start_ignored got led=%b busy=%b want 0 0", led, busy); end
        pulse_arm();
        n_cmp++; if (busy !== 1'b1 || led !== 1'b0)
            begin n_err++; $display("FAIL mid_rearm got busy=%b led=%b want 1 0", busy, led); end
    endtask

    initial begin
        reset_n = 1'b0;
        arm     = 1'b0;
        start   = 1'b0;
        button  = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_normal_press();
        test_rearm();
        test_early_press();
        test_simultaneous_start();
        test_timeout();
        test_tick_coincide();
        test_press_at_max();
        test_held_button();
        test_reset_mid_timing();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
